param_function_generator: RTL and testbench

- Parametrised DDS-style function generator. A phase accumulator drives waveform shaping with selectable waveform mode, square duty, and power-of-two amplitude attenuation.
- New frequency words are applied only at phase wrap, so frequency changes are glitch-free.
- Output is a registered unsigned sample word that feeds the board DAC / AnalogWave path; a wrap pulse is provided for scope triggering.

---
 rtl/param_function_generator.sv | 144 ++++++++++++++
 tb/tb_param_function_generator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_function_generator.sv
// param_function_generator
// DDS-style function generator: a phase accumulator feeds a waveform shaper
// (saw up/down, triangle, square with duty threshold, optional noise) followed
// by a power-of-two attenuator and an output register for the board DAC path.
//
// Build option:
//   FG_NOISE_EN - when defined, mode 4 outputs the top bits of a 16-bit
//                 Fibonacci LFSR (taps 16,14,13,11). When undefined, mode 4
//                 outputs 0 and no LFSR is built.
//
// Frequency load handshake (single rule for the whole block):
//   ld_freq is a one-cycle strobe with no back-pressure. On any edge where
//   ld_freq = 1 (enabled or not), freq_in is captured into a pending register
//   and freq_pending rises. The pending word moves into the active frequency
//   register only on an enabled edge that carries out of the accumulator
//   (phase wrap), or on the next enabled edge if the active frequency is 0
//   (a wrap could never occur). A strobe on the same edge as an apply refills
//   pending and keeps freq_pending high; back-to-back strobes before a wrap
//   overwrite pending, so only the newest word is applied.

module param_function_generator #(
    parameter int                 DATA_W     = 8,
    parameter int                 PHASE_W    = 16,
    parameter logic [PHASE_W-1:0] RESET_FREQ = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq_in,
    input  logic               ld_freq,
    input  logic [2:0]         mode,
    input  logic [DATA_W-1:0]  duty,
    input  logic [1:0]         amp_sel,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wrap_out,
    output logic               freq_pending
);

    // Waveform select encodings.
    localparam logic [2:0] MODE_SAW_UP   = 3'd0;
    localparam logic [2:0] MODE_SAW_DOWN = 3'd1;
    localparam logic [2:0] MODE_TRIANGLE = 3'd2;
    localparam logic [2:0] MODE_SQUARE   = 3'd3;
    localparam logic [2:0] MODE_NOISE    = 3'd4;

    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    // Accumulator and frequency registers.
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] freq_reg;
    logic [PHASE_W-1:0] pending;
    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               apply;

    // Shaper signals.
    logic [DATA_W-1:0]  p;
    logic [DATA_W-1:0]  p_dbl;
    logic [DATA_W-1:0]  shape;
    logic [DATA_W-1:0]  noise_sample;

    // Next accumulator value with the carry kept as an extra bit.
    assign sum   = {1'b0, phase} + {1'b0, freq_reg};
    assign carry = sum[PHASE_W];

    // A pending word is applied at a wrap, or straight away when the active
    // frequency is zero and the accumulator would otherwise never wrap.
    assign apply = en && freq_pending && (carry || (freq_reg == '0));

    // Top DATA_W bits of the phase drive the shaper; the doubled value is the
    // triangle ramp (its top bit is dropped, so the peak is all-ones minus 1).
    assign p     = phase[PHASE_W-1 -: DATA_W];
    assign p_dbl = {p[DATA_W-2:0], 1'b0};

`ifdef FG_NOISE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci feedback for x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // LFSR advances on every enabled edge; the non-zero seed keeps it out of
    // the lock-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (en) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign noise_sample = lfsr[15 -: DATA_W];
`else
    assign noise_sample = '0;
`endif

    // Waveform shaper working on the pre-increment phase.
    always_comb begin
        shape = '0;
        case (mode)
            MODE_SAW_UP:   shape = p;
            MODE_SAW_DOWN: shape = ~p;
            MODE_TRIANGLE: shape = phase[PHASE_W-1] ? ~p_dbl : p_dbl;
            MODE_SQUARE:   shape = (p < duty) ? ALL_ONES : '0;
            MODE_NOISE:    shape = noise_sample;
            default:       shape = '0;
        endcase
    end

    // Phase accumulator, output sample register and wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            wave_out <= '0;
            wrap_out <= 1'b0;
        end else if (en) begin
            phase    <= sum[PHASE_W-1:0];
            wave_out <= shape >> amp_sel;
            wrap_out <= carry;
        end else begin
            wrap_out <= 1'b0;
        end
    end

    // Frequency load handshake: capture on strobe, apply at wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_reg     <= RESET_FREQ;
            pending      <= '0;
            freq_pending <= 1'b0;
        end else begin
            if (apply) begin
                freq_reg <= pending;
            end
            if (ld_freq) begin
                pending      <= freq_in;
                freq_pending <= 1'b1;
            end else if (apply) begin
                freq_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_function_generator.sv
// tb_param_function_generator
// Directed bench for param_function_generator at DATA_W = 8, PHASE_W = 16,
// RESET_FREQ = 0. A table of shaper vectors is replayed with the accumulator
// stepping one output code per cycle (freq 16'h0100); hand-written sequences
// cover the load handshake, wrap periods, enable gating, async reset,
// attenuation changes mid-stream and the noise mode.

module tb_param_function_generator;

    localparam int DATA_W  = 8;
    localparam int PHASE_W = 16;

    // Clock / reset block
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b1;
    logic [PHASE_W-1:0] freq_in = '0;
    logic               ld_freq = 1'b0;
    logic [2:0]         mode = 3'd0;
    logic [DATA_W-1:0]  duty = '0;
    logic [1:0]         amp_sel = 2'd0;
    logic [DATA_W-1:0]  wave_out;
    logic               wrap_out;
    logic               freq_pending;

    always #5 clk = ~clk;

    param_function_generator #(
        .DATA_W(DATA_W),
        .PHASE_W(PHASE_W),
        .RESET_FREQ(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .freq_in(freq_in),
        .ld_freq(ld_freq),
        .mode(mode),
        .duty(duty),
        .amp_sel(amp_sel),
        .wave_out(wave_out),
        .wrap_out(wrap_out),
        .freq_pending(freq_pending)
    );

    // Scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic [2:0]        mode;
        logic [DATA_W-1:0] duty;
        logic [1:0]        amp;
        int                p;
        logic [DATA_W-1:0] exp_wave;
        logic              exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ld_freq = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Loads 16'h0100 from the reset frequency of 0. After this the last edge
    // output code 0 and each further edge outputs the next code.
    task automatic startup(input bit chk);
        freq_in = 16'h0100;
        ld_freq = 1'b1;
        tick();
        if (chk) check("pend_after_load", freq_pending, 1);
        ld_freq = 1'b0;
        tick();
        if (chk) check("pend_after_apply", freq_pending, 0);
        tick();
    endtask

    task automatic wait_wrap(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wrap_out && n < bound);
    endtask

    initial begin
        int n;

        vecs.push_back('{3'd0, 8'd0,   2'd0, 0,   8'd0,   1'b0});
        vecs.push_back('{3'd0, 8'd0,   2'd0, 1,   8'd1,   1'b0});
        vecs.push_back('{3'd0, 8'd0,   2'd0, 200, 8'd200, 1'b0});
        vecs.push_back('{3'd0, 8'd0,   2'd0, 255, 8'd255, 1'b1});
        vecs.push_back('{3'd1, 8'd0,   2'd0, 0,   8'd255, 1'b0});
        vecs.push_back('{3'd1, 8'd0,   2'd0, 37,  8'd218, 1'b0});
        vecs.push_back('{3'd2, 8'd0,   2'd0, 0,   8'd0,   1'b0});
        vecs.push_back('{3'd2, 8'd0,   2'd0, 127, 8'd254, 1'b0});
        vecs.push_back('{3'd2, 8'd0,   2'd0, 128, 8'd255, 1'b0});
        vecs.push_back('{3'd2, 8'd0,   2'd0, 129, 8'd253, 1'b0});
        vecs.push_back('{3'd2, 8'd0,   2'd0, 255, 8'd1,   1'b1});
        vecs.push_back('{3'd3, 8'd64,  2'd0, 0,   8'd255, 1'b0});
        vecs.push_back('{3'd3, 8'd64,  2'd0, 63,  8'd255, 1'b0});
        vecs.push_back('{3'd3, 8'd64,  2'd0, 64,  8'd0,   1'b0});
        vecs.push_back('{3'd3, 8'd0,   2'd0, 0,   8'd0,   1'b0});
        vecs.push_back('{3'd3, 8'd255, 2'd0, 254, 8'd255, 1'b0});
        vecs.push_back('{3'd3, 8'd255, 2'd0, 255, 8'd0,   1'b1});
        vecs.push_back('{3'd0, 8'd0,   2'd2, 7,   8'd1,   1'b0});
        vecs.push_back('{3'd0, 8'd0,   2'd2, 255, 8'd63,  1'b1});
        vecs.push_back('{3'd1, 8'd0,   2'd3, 0,   8'd31,  1'b0});
        vecs.push_back('{3'd2, 8'd0,   2'd1, 128, 8'd127, 1'b0});
        vecs.push_back('{3'd5, 8'd0,   2'd0, 10,  8'd0,   1'b0});
        vecs.push_back('{3'd6, 8'd0,   2'd0, 255, 8'd0,   1'b1});
        vecs.push_back('{3'd7, 8'd0,   2'd0, 200, 8'd0,   1'b0});

        // Reset state, observed while reset is still asserted.
        #2;
        check("reset_wave", wave_out, 0);
        check("reset_wrap", wrap_out, 0);
        check("reset_pend", freq_pending, 0);

        // Table-driven shaper vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            mode    = vecs[i].mode;
            duty    = vecs[i].duty;
            amp_sel = vecs[i].amp;
            en      = 1'b1;
            do_reset();
            startup(i == 0);
            repeat (vecs[i].p) tick();
            check($sformatf("vec%0d_wave", i), wave_out, vecs[i].exp_wave);
            check($sformatf("vec%0d_wrap", i), wrap_out, vecs[i].exp_wrap);
        end

        // Glitch-free frequency change: two loads mid-period, last one wins,
        // applied exactly at the wrap.
        mode = 3'd0; duty = '0; amp_sel = 2'd0; en = 1'b1;
        do_reset();
        startup(1'b0);
        repeat (100) tick();
        freq_in = 16'h0400; ld_freq = 1'b1; tick();
        freq_in = 16'h0200; ld_freq = 1'b1; tick();
        ld_freq = 1'b0;
        check("midperiod_pend", freq_pending, 1);
        check("midperiod_wave", wave_out, 102);
        wait_wrap(300, n);
        check("old_period_rest", n, 153);
        check("wrap_wave", wave_out, 255);
        check("pend_cleared_at_wrap", freq_pending, 0);
        tick();
        check("new_freq_s0", wave_out, 0);
        tick();
        check("new_freq_s1", wave_out, 2);
        wait_wrap(300, n);
        check("new_period_rest", n, 126);
        check("new_wrap_wave", wave_out, 254);

        // Disabled edges: state holds, wrap drops, load still captured.
        en = 1'b0; freq_in = 16'h0100; ld_freq = 1'b1;
        tick();
        ld_freq = 1'b0;
        check("dis_wrap", wrap_out, 0);
        check("dis_wave", wave_out, 254);
        check("dis_pend", freq_pending, 1);
        tick();
        check("dis_wave_hold", wave_out, 254);
        en = 1'b1;
        tick();
        check("reen_wave", wave_out, 0);
        check("reen_pend_no_wrap", freq_pending, 1);

        // Load on the same edge as an apply from a zero frequency.
        do_reset();
        freq_in = 16'h0100; ld_freq = 1'b1; tick();
        freq_in = 16'h0300; ld_freq = 1'b1; tick();
        ld_freq = 1'b0;
        check("reload_pend", freq_pending, 1);
        wait_wrap(400, n);
        check("reload_period1", n, 256);
        check("reload_pend_clear", freq_pending, 0);
        wait_wrap(200, n);
        check("reload_period2", n, 86);

        // Attenuation change mid-stream takes effect on the next sample.
        mode = 3'd0; amp_sel = 2'd2;
        do_reset();
        startup(1'b0);
        repeat (8) tick();
        check("amp2_p8", wave_out, 2);
        repeat (3) tick();
        check("amp2_p11", wave_out, 2);
        amp_sel = 2'd0;
        tick();
        check("amp0_p12", wave_out, 12);

        // Asynchronous reset mid-period.
        do_reset();
        startup(1'b0);
        repeat (50) tick();
        freq_in = 16'h0200; ld_freq = 1'b1; tick();
        ld_freq = 1'b0;
        check("pre_rst_wave", wave_out, 51);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wave", wave_out, 0);
        check("async_rst_wrap", wrap_out, 0);
        check("async_rst_pend", freq_pending, 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_first", wave_out, 0);
        repeat (3) tick();
        check("post_rst_freq_zero", wave_out, 0);

        // Noise mode.
        mode = 3'd4; amp_sel = 2'd0;
        do_reset();
`ifdef FG_NOISE_EN
        exp_q.push_back(8'hAC);
        exp_q.push_back(8'h59);
        exp_q.push_back(8'hB3);
        exp_q.push_back(8'h67);
`else
        repeat (4) exp_q.push_back(8'h00);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("noise%0d", i), wave_out, exp_q.pop_front());
        end
        amp_sel = 2'd1;
        tick();
`ifdef FG_NOISE_EN
        check("noise_amp1", wave_out, 8'h67);
`else
        check("noise_amp1", wave_out, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
